// File: rtl/tbl_sweep_arb_if.sv
// Requester and table-port bundle for tbl_sweep_arb.
// The slave modport is the arbiter side; master is the requesters plus the table.
interface tbl_sweep_arb_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 32
) ();
    logic [1:0]    req;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          rd_valid;
    logic          rd_id;
    logic [DW-1:0] rd_data;

    modport master (
        output req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
        input  gnt, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_id, rd_data
    );

    modport slave (
        input  req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
        output gnt, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_id, rd_data
    );
endinterface

// File: rtl/tbl_sweep_arb.sv
// Single-port table arbiter: two round-robin requesters plus a background fill sweep
// that only uses the port in cycles where no requester is granted.
module tbl_sweep_arb #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32
) (
    input  logic          clock,
    input  logic          resetN,
    input  logic          start,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          done,
    tbl_sweep_arb_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StSweep, StFinish} state_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [DW-1:0] fill_q;
    logic          last_q;
    logic          rd_valid_q;
    logic          rd_id_q;
    logic [1:0]    gnt;
    logic          gid;
    logic          sweep_wr;

    // Grant is gated by reset so nothing reaches the port while resetN is low.
    always_comb begin
        gnt = 2'b00;
        if (resetN) begin
            case (bus.req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gid      = gnt[1];
    assign sweep_wr = (state_q == StSweep) && (gnt == 2'b00);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSweep;
            StSweep:  if (sweep_wr && (ptr_q == LastAddr)) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q == StSweep);
        done          = (state_q == StFinish);
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt != 2'b00) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.req_we[gid];
            bus.mem_addr  = gid ? bus.req_addr1 : bus.req_addr0;
            bus.mem_wdata = gid ? bus.req_wdata1 : bus.req_wdata0;
        end else if (sweep_wr) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = ptr_q;
            bus.mem_wdata = fill_q;
        end
    end

    // Pointer stops at the last entry; the FSM leaves SWEEP on that write.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ptr_q      <= '0;
            fill_q     <= '0;
            last_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
        end else begin
            if ((state_q == StIdle) && start) begin
                ptr_q  <= '0;
                fill_q <= fill_data;
            end else if (sweep_wr && (ptr_q != LastAddr)) begin
                ptr_q <= ptr_q + AW'(1);
            end
            if (gnt != 2'b00) begin
                last_q  <= gid;
                rd_id_q <= gid;
            end
            rd_valid_q <= (gnt != 2'b00) && !bus.req_we[gid];
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_data  = rd_valid_q ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_tbl_sweep_arb.sv
// Directed bench for tbl_sweep_arb: arbitration vector table plus sweep sequences.
module tb_tbl_sweep_arb;
    logic        clock;
    logic        resetN;
    logic        start;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    tbl_sweep_arb_if #(.AW(7), .DW(32)) bus ();

    tbl_sweep_arb #(.DEPTH(128), .AW(7), .DW(32)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .start     (start),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [6:0]  a0;
        logic [6:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  gnt;
        logic        en;
        logic        mwe;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_sweep(input logic [31:0] fill, input int stall_at, input int restart_at,
                             input int abort_at, output int writes, output int busy_cyc,
                             output int done_cyc, output int done_cnt, output int bad);
        int         ptr;
        int         stall_left;
        bit         stalled;
        logic [6:0] pa;
        writes = 0; busy_cyc = 0; done_cyc = -1; done_cnt = 0; bad = 0;
        ptr = 0; stall_left = 0; stalled = 0;
        fill_data = fill;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        fill_data = ~fill;
        for (int k = 0; k < 400; k++) begin
            bus.req = 2'b00;
            start   = 1'b0;
            if (ptr == abort_at) begin
                resetN = 1'b0;
                #1;
                if (busy || done) bad++;
                repeat (3) begin
                    @(posedge clock); #1;
                    if (busy || done) bad++;
                end
                resetN = 1'b1;
                repeat (3) begin
                    @(posedge clock); #1;
                    if (busy || done) bad++;
                end
                break;
            end
            if (!stalled && ptr == stall_at) begin
                stalled    = 1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                bus.req       = 2'b01;
                bus.req_we    = 2'b01;
                bus.req_addr0 = 7'h55;
            end
            if (ptr == restart_at) start = 1'b1;
            #4;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            pa = 7'(ptr);
            if (stall_left > 0) begin
                if (bus.gnt != 2'b01 || bus.mem_addr != 7'h55) bad++;
                stall_left--;
            end else if (ptr < 128) begin
                if (bus.mem_en && bus.mem_we) writes++;
                if (!(bus.mem_en && bus.mem_we) || bus.mem_addr != pa || bus.mem_wdata != fill)
                    bad++;
                ptr++;
            end else if (bus.mem_en) begin
                bad++;
            end
            @(posedge clock); #1;
            if (done_cnt > 0 && k >= done_cyc + 3) break;
        end
        bus.req = 2'b00;
        start   = 1'b0;
    endtask

    initial begin
        int w, b, dc, dn, bad;
        logic       prev_rd;
        logic       prev_id;

        tbl[0]  = '{2'b00, 2'b00, 7'd1, 7'd2, 32'hAAAA, 32'hBBBB, 2'b00, 1'b0, 1'b0, 7'd0, 32'h0};
        tbl[1]  = '{2'b11, 2'b00, 7'd3, 7'd5, 32'h11, 32'h22, 2'b01, 1'b1, 1'b0, 7'd3, 32'h11};
        tbl[2]  = '{2'b11, 2'b00, 7'd3, 7'd5, 32'h11, 32'h22, 2'b10, 1'b1, 1'b0, 7'd5, 32'h22};
        tbl[3]  = '{2'b11, 2'b00, 7'd3, 7'd5, 32'h11, 32'h22, 2'b01, 1'b1, 1'b0, 7'd3, 32'h11};
        tbl[4]  = '{2'b11, 2'b00, 7'd3, 7'd5, 32'h11, 32'h22, 2'b10, 1'b1, 1'b0, 7'd5, 32'h22};
        tbl[5]  = '{2'b10, 2'b10, 7'd4, 7'd9, 32'h33, 32'hDEAD, 2'b10, 1'b1, 1'b1, 7'd9, 32'hDEAD};
        tbl[6]  = '{2'b11, 2'b11, 7'd4, 7'd9, 32'h33, 32'h44, 2'b01, 1'b1, 1'b1, 7'd4, 32'h33};
        tbl[7]  = '{2'b01, 2'b01, 7'd2, 7'd6, 32'hBEEF, 32'h55, 2'b01, 1'b1, 1'b1, 7'd2, 32'hBEEF};
        tbl[8]  = '{2'b11, 2'b10, 7'd2, 7'd6, 32'h66, 32'h77, 2'b10, 1'b1, 1'b1, 7'd6, 32'h77};
        tbl[9]  = '{2'b11, 2'b01, 7'd8, 7'd6, 32'h99, 32'h77, 2'b01, 1'b1, 1'b1, 7'd8, 32'h99};
        tbl[10] = '{2'b00, 2'b11, 7'h7F, 7'h7E, 32'hFFFF, 32'hEEEE, 2'b00, 1'b0, 1'b0, 7'd0, 32'h0};

        resetN = 1'b0; start = 1'b0; fill_data = '0;
        bus.req = 2'b00; bus.req_we = 2'b00; bus.req_addr0 = '0; bus.req_addr1 = '0;
        bus.req_wdata0 = '0; bus.req_wdata1 = '0; bus.mem_rdata = '0;

        // Reset state, with requests asserted to show the grant is gated.
        #12;
        bus.req = 2'b11;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_rd_id", 32'(bus.rd_id), 32'h0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        bus.req = 2'b00;
        @(posedge clock); #1;
        resetN = 1'b1;
        @(posedge clock); #1;

        prev_rd = 1'b0;
        prev_id = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus.req        = tbl[i].req;
            bus.req_we     = tbl[i].we;
            bus.req_addr0  = tbl[i].a0;
            bus.req_addr1  = tbl[i].a1;
            bus.req_wdata0 = tbl[i].d0;
            bus.req_wdata1 = tbl[i].d1;
            #4;
            chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_mem_en", i), 32'(bus.mem_en), 32'(tbl[i].en));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(tbl[i].mwe));
            chk($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].addr));
            chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, tbl[i].wdata);
            chk($sformatf("v%0d_rd_valid", i), 32'(bus.rd_valid), 32'(prev_rd));
            if (prev_rd) chk($sformatf("v%0d_rd_id", i), 32'(bus.rd_id), 32'(prev_id));
            prev_rd = (tbl[i].gnt != 2'b00) && !tbl[i].mwe;
            prev_id = tbl[i].gnt[1];
            @(posedge clock); #1;
        end
        bus.req = 2'b00;

        // Read return from requester 1.
        bus.req = 2'b10; bus.req_we = 2'b00; bus.req_addr1 = 7'd7; bus.mem_rdata = '0;
        #4;
        chk("rd_req_gnt", 32'(bus.gnt), 32'h2);
        chk("rd_req_addr", 32'(bus.mem_addr), 32'd7);
        chk("rd_req_we", 32'(bus.mem_we), 32'h0);
        @(posedge clock); #1;
        bus.req = 2'b00; bus.mem_rdata = 32'h1234;
        #4;
        chk("rd_ret_valid", 32'(bus.rd_valid), 32'h1);
        chk("rd_ret_id", 32'(bus.rd_id), 32'h1);
        chk("rd_ret_data", bus.rd_data, 32'h1234);
        @(posedge clock); #1;
        #4;
        chk("rd_ret_pulse", 32'(bus.rd_valid), 32'h0);
        @(posedge clock); #1;
        bus.mem_rdata = '0;

        run_sweep(32'hA5A5_0000, -1, -1, -1, w, b, dc, dn, bad);
        chk("idle_writes", w, 128);
        chk("idle_busy", b, 128);
        chk("idle_done_cyc", dc, 128);
        chk("idle_done_cnt", dn, 1);
        chk("idle_order", bad, 0);

        run_sweep(32'h0BAD_F00D, 10, -1, -1, w, b, dc, dn, bad);
        chk("stall_writes", w, 128);
        chk("stall_busy", b, 133);
        chk("stall_done_cyc", dc, 133);
        chk("stall_done_cnt", dn, 1);
        chk("stall_order", bad, 0);

        run_sweep(32'h1357_9BDF, -1, 50, -1, w, b, dc, dn, bad);
        chk("restart_writes", w, 128);
        chk("restart_done_cyc", dc, 128);
        chk("restart_done_cnt", dn, 1);
        chk("restart_order", bad, 0);

        run_sweep(32'hCAFE_0001, -1, -1, 64, w, b, dc, dn, bad);
        chk("abort_writes", w, 64);
        chk("abort_busy", b, 64);
        chk("abort_done_cnt", dn, 0);
        chk("abort_clean", bad, 0);

        run_sweep(32'h0F0F_1234, -1, -1, -1, w, b, dc, dn, bad);
        chk("post_abort_writes", w, 128);
        chk("post_abort_done_cyc", dc, 128);
        chk("post_abort_order", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
